jtmikie_romslot: RTL and testbench
==================================

Name: jtmikie_romslot

Overview:
- Responder end of the game-side ROM request interface (addr/cs -> data/ok) used by the main CPU, sound CPU and tile/object fetchers.
- Accepts a byte-wide request from one client.
- Fetches the enclosing 16-bit word from the SDRAM controller through a request/ack/data-strobe handshake.
- Caches that word and raises ok once the data matches the current address. It sits between a game module and the shared SDRAM arbiter.

Parameters:
- AW, 13, client byte-address width.
- OFFSET, 22'h0, SDRAM word offset added to every fetch address (e.g. SND_START, SCR_START).
- LATCH, 0, when 1 client addr/cs are registered one cycle before compare; when 0 compare is on live inputs.

Ports:
- clk  in  1  system clock, every register on rising edge
- rst_n  in  1  synchronous active-low reset
- slot_cs  in  1  client request valid
- slot_addr  in  AW  client byte address
- slot_dout  out  8  byte at slot_addr
- slot_ok  out  1  slot_dout valid for current slot_addr
- sdram_req  out  1  fetch request to arbiter
- sdram_addr  out  22  SDRAM word address = OFFSET + slot_addr[AW-1:1]
- sdram_ack  in  1  arbiter accepted request (one-cycle pulse)
- sdram_dst  in  1  data strobe; sdram_din valid this cycle
- sdram_din  in  16  fetched word, low byte = even address

Behaviour:
- Reset (rst_n=0 at clk edge): slot_ok=0, slot_dout=0, sdram_req=0, sdram_addr=0, cache valid=0, state=IDLE. Reset mid-fetch abandons it; a late sdram_dst after reset is ignored.
- Cache: one 16-bit word, tag = word address (AW-1 bits), valid bit.
- Hit = cs & valid & tag==addr[AW-1:1]. Output is registered: slot_ok=1 and slot_dout=byte(addr[0]) one cycle after hit. slot_ok drops one cycle after addr leaves the cached word or cs falls.
- State IDLE: on cs & ~hit -> REQ. Assert sdram_req and load sdram_addr in the same cycle.
- State REQ: hold sdram_req and sdram_addr stable until sdram_ack. On ack: deassert sdram_req the next cycle and go to WAIT. ack and dst in the same cycle go straight to FILL handling.
- State WAIT: on sdram_dst, latch sdram_din, set tag and valid, go to IDLE.
- Address change during REQ/WAIT: the fetch completes and is cached anyway, since the arbiter cannot cancel. Back in IDLE a miss starts a new fetch. slot_ok never asserts for stale data.
- cs low in IDLE: no request. cs low mid-fetch: fetch completes and caches.
- Wrap-around: OFFSET + address computed modulo 2^22.
- Minimum miss latency (ack and dst each one cycle after previous step): req cycle 0, ack 1, dst 2, slot_ok 4.
- Same-word odd/even access: hit, 1-cycle latency, no SDRAM traffic.

Optional Feature:
- Macro JTMIKIE_ROMSLOT_DBL_EN.
- Defined: two cache entries with one-bit LRU. Hit on either entry. A fill replaces the LRU entry; a hit or fill marks that entry MRU. Reset clears both valid bits and sets LRU to entry 0.
- Undefined: single entry exactly as above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with cs=1, addr=0x0100 -> slot_ok=0, sdram_req=0 throughout. After release, sdram_req=1 with sdram_addr=OFFSET+0x080.
- Miss then hit: addr=0x0005, ack at +1, dst at +2 with din=0xBEEF -> slot_dout=0xBE, slot_ok=1 at cycle 4. Then addr=0x0004 -> slot_dout=0xEF, ok next cycle, no new sdram_req.
- Address change mid-fetch: addr 0x0010 -> 0x0020 while in WAIT -> 0x0010 word cached, slot_ok stays 0, second request with sdram_addr=OFFSET+0x010, ok after its dst.
- Delayed ack: ack withheld 20 cycles -> sdram_req and sdram_addr stable all 20 cycles, single request only.
- Reset mid-fetch: rst_n=0 in WAIT, dst arrives during reset -> valid=0 after reset, next cs re-fetches.
- With JTMIKIE_ROMSLOT_DBL_EN: access words A, B, A, C -> C replaces B. A then hits with no sdram_req; B re-fetches.

Source files
------------

// File: rtl/jtmikie_romslot_if.sv
// ROM slot bus: client byte request/response plus the SDRAM word-fetch handshake.
// The responder (jtmikie_romslot) uses the slave modport; client and arbiter models use master.
interface jtmikie_romslot_if #(
    parameter int AW = 13
);
    logic          slot_cs;
    logic [AW-1:0] slot_addr;
    logic [7:0]    slot_dout;
    logic          slot_ok;
    logic          sdram_req;
    logic [21:0]   sdram_addr;
    logic          sdram_ack;
    logic          sdram_dst;
    logic [15:0]   sdram_din;

    modport master (
        output slot_cs, slot_addr, sdram_ack, sdram_dst, sdram_din,
        input  slot_dout, slot_ok, sdram_req, sdram_addr
    );

    modport slave (
        input  slot_cs, slot_addr, sdram_ack, sdram_dst, sdram_din,
        output slot_dout, slot_ok, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtmikie_romslot.sv
// ROM slot responder: byte requests served from a cached 16-bit SDRAM word (JTMIKIE_ROMSLOT_DBL_EN: 2 entries, LRU).
// Latency: hit -> slot_ok next cycle; miss -> slot_ok two cycles after the sdram_dst strobe.
// Backpressure: sdram_req/sdram_addr held until sdram_ack; an issued fetch always completes and is cached.
module jtmikie_romslot #(
    parameter int          AW     = 13,
    parameter logic [21:0] OFFSET = 22'h0,
    parameter bit          LATCH  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    jtmikie_romslot_if.slave bus
);

`ifdef JTMIKIE_ROMSLOT_DBL_EN
    localparam int NE = 2;
`else
    localparam int NE = 1;
`endif

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state;
    logic          cmp_cs;
    logic [AW-1:0] cmp_addr;
    logic [AW-2:0] cmp_tag;
    logic [AW-2:0] fetch_tag;
    logic [AW-2:0] tag  [NE];
    logic [15:0]   word [NE];
    logic [NE-1:0] valid;
    logic [NE-1:0] hit_vec;
    logic          hit;
    logic [15:0]   hit_word;
    logic          fill;
    logic          victim;
    logic          req_r;
    logic [21:0]   addr_r;
    logic          ok_r;
    logic [7:0]    dout_r;

    generate
        if (LATCH) begin : g_latch
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cmp_cs   <= 1'b0;
                    cmp_addr <= '0;
                end else begin
                    cmp_cs   <= bus.slot_cs;
                    cmp_addr <= bus.slot_addr;
                end
            end
        end else begin : g_live
            assign cmp_cs   = bus.slot_cs;
            assign cmp_addr = bus.slot_addr;
        end
    endgenerate

    assign cmp_tag = cmp_addr[AW-1:1];

    always_comb begin
        hit_vec  = '0;
        hit_word = 16'h0;
        for (int i = 0; i < NE; i++) begin
            hit_vec[i] = cmp_cs & valid[i] & (tag[i] == cmp_tag);
            if (hit_vec[i]) hit_word = word[i];
        end
    end

    assign hit  = |hit_vec;
    // Data may land in the same cycle as the ack, so both states can complete a fill.
    assign fill = bus.sdram_dst & ((state == WAIT) | ((state == REQ) & bus.sdram_ack));

`ifdef JTMIKIE_ROMSLOT_DBL_EN
    logic lru;
    assign victim = lru;
`else
    assign victim = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            req_r  <= 1'b0;
            addr_r <= '0;
            ok_r   <= 1'b0;
            dout_r <= '0;
            valid  <= '0;
`ifdef JTMIKIE_ROMSLOT_DBL_EN
            lru    <= 1'b0;
`endif
        end else begin
            ok_r <= hit;
            if (hit) dout_r <= cmp_addr[0] ? hit_word[15:8] : hit_word[7:0];

            case (state)
                IDLE: if (cmp_cs && !hit) begin
                    req_r     <= 1'b1;
                    addr_r    <= OFFSET + 22'(cmp_tag);
                    fetch_tag <= cmp_tag;
                    state     <= REQ;
                end
                REQ: if (bus.sdram_ack) begin
                    req_r <= 1'b0;
                    state <= fill ? IDLE : WAIT;
                end
                WAIT: if (fill) state <= IDLE;
                default: state <= IDLE;
            endcase

`ifdef JTMIKIE_ROMSLOT_DBL_EN
            if (hit)  lru <= hit_vec[0];
            if (fill) lru <= ~victim;
`endif
            // The tag comes from the issued fetch, not the live address, which may have moved on.
            for (int i = 0; i < NE; i++) begin
                if (fill && (i == int'(victim))) begin
                    tag[i]   <= fetch_tag;
                    word[i]  <= bus.sdram_din;
                    valid[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.sdram_req  = req_r;
    assign bus.sdram_addr = addr_r;
    assign bus.slot_ok    = ok_r;
    assign bus.slot_dout  = dout_r;

endmodule

// File: tb/tb_jtmikie_romslot.sv
// Bench for jtmikie_romslot: directed client/arbiter stimulus, scoreboard queues for requests and ok events.
// Also covers the two-entry LRU cache when JTMIKIE_ROMSLOT_DBL_EN is defined.
module tb_jtmikie_romslot;
    localparam int          AW     = 13;
    localparam logic [21:0] OFFSET = 22'h3FFF80;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [21:0] req_q[$];
    logic [7:0]  ok_byte_q[$];
    int          ok_cyc_q[$];
    logic        prev_req = 1'b0;
    logic        prev_ok  = 1'b0;
    bit          got;

    jtmikie_romslot_if #(.AW(AW)) bus ();

    jtmikie_romslot #(.AW(AW), .OFFSET(OFFSET), .LATCH(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each new request and each rising slot_ok must match the head of its queue.
    always @(negedge clk) begin
        if (bus.sdram_req === 1'b1 && prev_req !== 1'b1) begin
            if (req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_unexpected: sdram_req rose with addr %0h, none expected (cycle %0d)", bus.sdram_addr, cyc);
            end else begin
                check("req_addr", 32'(bus.sdram_addr), 32'(req_q.pop_front()));
            end
        end
        if (bus.slot_ok === 1'b1 && prev_ok !== 1'b1) begin
            if (ok_byte_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ok_unexpected: slot_ok rose with dout %0h, none expected (cycle %0d)", bus.slot_dout, cyc);
            end else begin
                check("ok_dout", 32'(bus.slot_dout), 32'(ok_byte_q.pop_front()));
                check("ok_cycle", 32'(cyc), 32'(ok_cyc_q.pop_front()));
            end
        end
        prev_req = bus.sdram_req;
        prev_ok  = bus.slot_ok;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cs, input logic [AW-1:0] a);
        bus.slot_cs   = cs;
        bus.slot_addr = a;
    endtask

    task automatic push_ok(input logic [7:0] b, input int c);
        ok_byte_q.push_back(b);
        ok_cyc_q.push_back(c);
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (bus.sdram_req === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: sdram_req not seen within 64 cycles (cycle %0d)", cyc);
        end
    endtask

    // Arbiter model: ack ack_d cycles after the request, dst with the ack or one cycle later.
    // Returns in the cycle where the expected slot_ok is visible.
    task automatic serve(input int ack_d, input bit together, input bit exp_ok,
                         input logic [7:0] exp_byte, input logic [15:0] din);
        bit          seen;
        int          held;
        logic [21:0] a0;
        wait_req(seen);
        if (!seen) return;
        a0   = bus.sdram_addr;
        held = 0;
        for (int i = 1; i < ack_d; i++) begin
            step();
            if (bus.sdram_req === 1'b1 && bus.sdram_addr === a0) held++;
        end
        step();
        bus.sdram_ack = 1'b1;
        if (together) begin
            bus.sdram_dst = 1'b1;
            bus.sdram_din = din;
            if (exp_ok) push_ok(exp_byte, cyc + 2);
        end
        step();
        bus.sdram_ack = 1'b0;
        bus.sdram_dst = 1'b0;
        check("req_drop", 32'(bus.sdram_req), 32'd0);
        check("req_hold", 32'(held), 32'(ack_d - 1));
        if (!together) begin
            bus.sdram_dst = 1'b1;
            bus.sdram_din = din;
            if (exp_ok) push_ok(exp_byte, cyc + 2);
            step();
            bus.sdram_dst = 1'b0;
        end
        step();
    endtask

    task automatic access(input logic [AW-1:0] a, input logic [21:0] exp_addr,
                          input logic [15:0] din, input logic [7:0] exp_byte);
        drive(1'b1, a);
        req_q.push_back(exp_addr);
        serve(1, 1'b0, 1'b1, exp_byte, din);
    endtask

    task automatic hit_access(input logic [AW-1:0] a, input logic [7:0] exp_byte);
        drive(1'b0, a);
        step();
        drive(1'b1, a);
        push_ok(exp_byte, cyc + 1);
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.sdram_ack = 1'b0;
        bus.sdram_dst = 1'b0;
        bus.sdram_din = 16'h0;
        drive(1'b1, 13'h0100);

        // Reset held three cycles with a pending client request
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ok", 32'(bus.slot_ok), 32'd0);
            check("rst_req", 32'(bus.sdram_req), 32'd0);
        end
        check("rst_dout", 32'(bus.slot_dout), 32'd0);
        check("rst_addr", 32'(bus.sdram_addr), 32'd0);
        req_q.push_back(22'h000000);      // OFFSET + 0x080 wraps to zero
        rst_n = 1'b1;
        serve(1, 1'b1, 1'b1, 8'hA5, 16'h00A5);

        // Minimum-latency miss on an odd byte, then the even byte of the same word
        access(13'h0005, 22'h3FFF82, 16'hBEEF, 8'hBE);
        check("ok_hold", 32'(bus.slot_ok), 32'd1);
        drive(1'b0, 13'h0005);
        step();
        check("ok_drop_cs", 32'(bus.slot_ok), 32'd0);
        drive(1'b1, 13'h0004);
        push_ok(8'hEF, cyc + 1);
        step();
        step();

        // Address moves while the fetch waits for data
        drive(1'b1, 13'h0010);
        req_q.push_back(22'h3FFF88);
        wait_req(got);
        step();
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        drive(1'b1, 13'h0020);
        req_q.push_back(22'h3FFF90);
        step();
        bus.sdram_dst = 1'b1;
        bus.sdram_din = 16'h1234;
        step();
        bus.sdram_dst = 1'b0;
        serve(1, 1'b0, 1'b1, 8'hFE, 16'hCAFE);

        // Ack withheld for 20 cycles at the top of the address range
        drive(1'b1, 13'h1FFE);
        req_q.push_back(22'h000F7F);
        serve(21, 1'b0, 1'b1, 8'h5C, 16'h9A5C);

        // Reset while waiting for data; strobes during and after reset are ignored
        drive(1'b1, 13'h0040);
        req_q.push_back(22'h3FFFA0);
        wait_req(got);
        step();
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        rst_n = 1'b0;
        step();
        bus.sdram_dst = 1'b1;
        bus.sdram_din = 16'h1111;
        check("rst2_req", 32'(bus.sdram_req), 32'd0);
        check("rst2_ok", 32'(bus.slot_ok), 32'd0);
        step();
        bus.sdram_dst = 1'b0;
        rst_n = 1'b1;
        drive(1'b0, 13'h0040);
        step();
        bus.sdram_dst = 1'b1;
        bus.sdram_din = 16'h3333;
        step();
        bus.sdram_dst = 1'b0;
        check("idle_req", 32'(bus.sdram_req), 32'd0);
        check("idle_ok", 32'(bus.slot_ok), 32'd0);
        access(13'h0040, 22'h3FFFA0, 16'h5522, 8'h22);

        // Replacement: words A, B, A, C, then A and B again
        access(13'h0A00, 22'h000480, 16'h7711, 8'h11);
        access(13'h0B00, 22'h000500, 16'h7722, 8'h22);
`ifdef JTMIKIE_ROMSLOT_DBL_EN
        hit_access(13'h0A00, 8'h11);
        access(13'h0C01, 22'h000580, 16'h3344, 8'h33);
        hit_access(13'h0A00, 8'h11);
        access(13'h0B00, 22'h000500, 16'h7766, 8'h66);
`else
        access(13'h0A00, 22'h000480, 16'h7733, 8'h33);
        hit_access(13'h0A01, 8'h77);
`endif

        drive(1'b0, 13'h0000);
        repeat (4) step();
        check("req_q_empty", 32'(req_q.size()), 32'd0);
        check("ok_q_empty", 32'(ok_byte_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
